// File: rtl/pc_unit.sv
// Fetch program counter with trap/branch/return redirects and a run/halt FSM.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INC          = 4,
  parameter int              ALIGN_BITS   = 2,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            imem_ready,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_next_seq,
  output logic            misalign,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_valid
);

  // state  | meaning
  // S_BOOT | first cycle after reset, no fetch issued yet
  // S_RUN  | fetching, redirects honoured
  // S_HALT | stopped after a misaligned branch, waits for a trap
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << ALIGN_BITS) - XLEN'(1));

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic            pop_taken;
  logic            ras_valid_i;
  logic [XLEN-1:0] ras_top_i;
  logic [XLEN-1:0] trap_pc;
  logic            br_misaligned;

  assign trap_pc       = trap_vector & ALIGN_MASK;
  assign br_misaligned = |(br_target & ~ALIGN_MASK);
  assign pc_next_seq   = pc_q + XLEN'(INC);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    pop_taken  = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
        if (trap) pc_d = trap_pc;
      end
      S_RUN: begin
        if (trap) begin
          pc_d = trap_pc;
        end else if (br_taken) begin
          if (br_misaligned) begin
            misalign_d = 1'b1;
            state_d    = S_HALT;
          end else begin
            pc_d = br_target;
          end
        end else if (ras_pop && ras_valid_i) begin
          pc_d      = ras_top_i;
          pop_taken = 1'b1;
        end else if (imem_ready && !stall) begin
          pc_d = pc_next_seq;
        end
      end
      S_HALT: begin
        if (trap) begin
          state_d = S_RUN;
          pc_d    = trap_pc;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef PC_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] ras_mem_q [RAS_DEPTH];
  logic [XLEN-1:0] ras_mem_d [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d, ptr_inc;
  logic [CW-1:0]   cnt_q, cnt_d;

  assign ptr_inc     = ptr_q + PW'(1);
  assign ras_valid_i = (cnt_q != '0);
  assign ras_top_i   = ras_valid_i ? ras_mem_q[ptr_q] : '0;

  // Circular buffer: a push when full silently overwrites the oldest entry.
  always_comb begin
    ras_mem_d = ras_mem_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    if (ras_push && pop_taken) begin
      ras_mem_d[ptr_q] = pc_next_seq;
    end else if (ras_push) begin
      ras_mem_d[ptr_inc] = pc_next_seq;
      ptr_d              = ptr_inc;
      if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + CW'(1);
    end else if (pop_taken) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem_q[i] <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ras_mem_q <= ras_mem_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end
`else
  logic unused_ras;
  assign ras_valid_i = 1'b0;
  assign ras_top_i   = '0;
  assign unused_ras  = ras_push ^ pop_taken;
`endif

  assign pc        = pc_q;
  assign pc_valid  = (state_q == S_RUN);
  assign misalign  = misalign_q;
  assign ras_top   = ras_top_i;
  assign ras_valid = ras_valid_i;

endmodule

// File: tb/tb_pc_unit.sv
// Directed and randomized checks of pc_unit against a behavioural fetch model.
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall, imem_ready, br_taken, trap, ras_push, ras_pop;
  logic [31:0] br_target, trap_vector;
  logic [31:0] pc, pc_next_seq, ras_top;
  logic        pc_valid, misalign, ras_valid;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef PC_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  pc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .imem_ready  (imem_ready),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .trap        (trap),
    .trap_vector (trap_vector),
    .ras_push    (ras_push),
    .ras_pop     (ras_pop),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .pc_next_seq (pc_next_seq),
    .misalign    (misalign),
    .ras_top     (ras_top),
    .ras_valid   (ras_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  bit [31:0] m_pc;
  bit        m_booted, m_halted, m_mis;
  bit [31:0] m_ras[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc     = 32'h0;
    m_booted = 1'b0;
    m_halted = 1'b0;
    m_mis    = 1'b0;
    m_ras.delete();
  endtask

  task automatic model_step(input bit st, input bit rdy, input bit br, input bit [31:0] tgt,
                            input bit tr, input bit [31:0] tv, input bit psh, input bit pop);
    bit [31:0] seq;
    bit        popped;
    seq    = m_pc + 32'd4;
    popped = 1'b0;
    m_mis  = 1'b0;
    if (!m_booted) begin
      m_booted = 1'b1;
      if (tr) m_pc = {tv[31:2], 2'b00};
    end else if (m_halted) begin
      if (tr) begin
        m_halted = 1'b0;
        m_pc     = {tv[31:2], 2'b00};
      end
    end else if (tr) begin
      m_pc = {tv[31:2], 2'b00};
    end else if (br) begin
      if (tgt[1:0] != 2'b00) begin
        m_mis    = 1'b1;
        m_halted = 1'b1;
      end else begin
        m_pc = tgt;
      end
    end else if (RAS_EN && pop && m_ras.size() > 0) begin
      m_pc   = m_ras[0];
      popped = 1'b1;
    end else if (rdy && !st) begin
      m_pc = seq;
    end
    if (RAS_EN) begin
      if (psh && popped) begin
        m_ras[0] = seq;
      end else if (psh) begin
        m_ras.push_front(seq);
        if (m_ras.size() > 4) void'(m_ras.pop_back());
      end else if (popped) begin
        void'(m_ras.pop_front());
      end
    end
  endtask

  task automatic check_all(input string ctx);
    check_val({ctx, ".pc"}, pc, m_pc);
    check_val({ctx, ".pc_valid"}, {31'b0, pc_valid}, {31'b0, m_booted && !m_halted});
    check_val({ctx, ".misalign"}, {31'b0, misalign}, {31'b0, m_mis});
    check_val({ctx, ".pc_next_seq"}, pc_next_seq, m_pc + 32'd4);
    check_val({ctx, ".ras_valid"}, {31'b0, ras_valid}, {31'b0, m_ras.size() > 0});
    check_val({ctx, ".ras_top"}, ras_top, (m_ras.size() > 0) ? m_ras[0] : 32'h0);
  endtask

  task automatic cycle(input string ctx, input bit st, input bit rdy, input bit br,
                       input bit [31:0] tgt, input bit tr, input bit [31:0] tv,
                       input bit psh, input bit pop);
    stall = st; imem_ready = rdy; br_taken = br; br_target = tgt;
    trap = tr; trap_vector = tv; ras_push = psh; ras_pop = pop;
    model_step(st, rdy, br, tgt, tr, tv, psh, pop);
    @(posedge clk);
    @(negedge clk);
    check_all(ctx);
  endtask

  initial begin
    reset = 1'b0;
    stall = 0; imem_ready = 0; br_taken = 0; trap = 0; ras_push = 0; ras_pop = 0;
    br_target = '0; trap_vector = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b1;

    for (int i = 0; i < 5; i++) cycle("boot_seq", 0, 1, 0, 0, 0, 0, 0, 0);
    check_val("seq_reaches_0x10", pc, 32'h10);
    for (int i = 0; i < 3; i++) cycle("stall", 1, 1, 0, 0, 0, 0, 0, 0);
    cycle("br_in_stall", 1, 1, 1, 32'h40, 0, 0, 0, 0);
    check_val("br_in_stall_0x40", pc, 32'h40);
    cycle("trap_vs_br", 0, 1, 1, 32'h80, 1, 32'h103, 0, 0);
    check_val("trap_wins_0x100", pc, 32'h100);
    cycle("hold_not_ready", 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("push_pre", 0, 1, 0, 0, 0, 0, 1, 0);
    cycle("br_misaligned", 0, 1, 1, 32'h42, 0, 0, 0, 0);
    check_val("misalign_pulse", {31'b0, misalign}, 32'h1);
    cycle("halt_br", 0, 1, 1, 32'h80, 0, 0, 0, 0);
    cycle("halt_pop", 0, 1, 0, 0, 0, 0, 0, 1);
    cycle("halt_trap", 0, 1, 0, 0, 1, 32'h200, 0, 0);
    check_val("resume_0x200", pc, 32'h200);
    cycle("pop_one", 0, 1, 0, 0, 0, 0, 0, 1);
    cycle("br_top", 0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    cycle("wrap", 0, 1, 0, 0, 0, 0, 0, 0);
    check_val("wrap_to_0", pc, 32'h0);
    for (int i = 0; i < 5; i++) cycle("ras_push", 0, 1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cycle("ras_pop", 0, 1, 0, 0, 0, 0, 0, 1);
    cycle("push2_a", 0, 1, 0, 0, 0, 0, 1, 0);
    cycle("push2_b", 0, 1, 0, 0, 0, 0, 1, 0);
    cycle("push_pop", 0, 1, 0, 0, 0, 0, 1, 1);
    cycle("pop_vs_br", 0, 1, 1, 32'h500, 0, 0, 0, 1);

    #2 reset = 1'b0;
    #1 model_reset();
    check_all("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    cycle("boot_trap", 0, 1, 0, 0, 1, 32'h301, 0, 0);
    check_val("boot_trap_0x300", pc, 32'h300);

    for (int i = 0; i < 3000; i++) begin
      bit [31:0] tgt;
      int        r;
      r = $urandom_range(0, 9);
      if (r == 0)      tgt = $urandom;
      else if (r == 1) tgt = 32'hFFFF_FFF0 | ($urandom & 32'hC);
      else             tgt = $urandom & 32'hFFFF_FFFC;
      cycle("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0, tgt, $urandom_range(0, 19) == 0, $urandom,
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
